// File: rtl/avg_pkg.sv
// Shared widths, FSM state type and delta helper for the AVG line rasterizer.
package avg_pkg;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 3;
  localparam int ERR_W   = 14;
  localparam int DELTA_W = COORD_W + 1;

  typedef enum logic {RS_IDLE, RS_DRAW} raster_state_t;

  // |b - a| for two unsigned coordinates, as a non-negative signed delta.
  function automatic logic signed [DELTA_W-1:0] abs_delta(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    logic signed [DELTA_W-1:0] d;
    d = $signed({1'b0, b}) - $signed({1'b0, a});
    return d[DELTA_W-1] ? -d : d;
  endfunction
endpackage

// File: rtl/avg_line_raster_line_step.sv
// One Bresenham step: next point and next error term from the current ones.
module line_step
  import avg_pkg::*;
(
  input  logic        [COORD_W-1:0] cur_x,
  input  logic        [COORD_W-1:0] cur_y,
  input  logic signed [ERR_W-1:0]   err,
  input  logic signed [DELTA_W-1:0] dx,
  input  logic signed [DELTA_W-1:0] dy,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  output logic        [COORD_W-1:0] next_x,
  output logic        [COORD_W-1:0] next_y,
  output logic signed [ERR_W-1:0]   next_err
);
  logic signed [ERR_W-1:0] e2;
  logic signed [ERR_W-1:0] dx_e;
  logic signed [ERR_W-1:0] dy_e;
  logic                    step_x;
  logic                    step_y;

  assign dx_e = {{(ERR_W-DELTA_W){dx[DELTA_W-1]}}, dx};
  assign dy_e = {{(ERR_W-DELTA_W){dy[DELTA_W-1]}}, dy};
  assign e2   = err <<< 1;

  // Both decisions use the pre-step error, so a diagonal step applies both.
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);

  assign next_err = err + (step_x ? dy_e : '0) + (step_y ? dx_e : '0);

  always_comb begin
    next_x = cur_x;
    next_y = cur_y;
    if (step_x) next_x = sx_neg ? cur_x - COORD_W'(1) : cur_x + COORD_W'(1);
    if (step_y) next_y = sy_neg ? cur_y - COORD_W'(1) : cur_y + COORD_W'(1);
  end
endmodule

// File: rtl/avg_line_raster.sv
// Pops lines from the AVG line queue and emits clipped Bresenham pixel writes.
module avg_line_raster
  import avg_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [COORD_W-1:0]  QStartX,
  input  logic [COORD_W-1:0]  QStartY,
  input  logic [COORD_W-1:0]  QEndX,
  input  logic [COORD_W-1:0]  QEndY,
  input  logic [COLOR_W-1:0]  QColor,
  input  logic                empty,
  output logic                read,
  output logic [COORD_W-1:0]  pixX,
  output logic [COORD_W-1:0]  pixY,
  output logic [COLOR_W-1:0]  pixColor,
  output logic                pixWrite,
  input  logic                pixReady,
  output logic                busy,
  output raster_state_t       state_dbg
);
  localparam logic [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_H);

  // Handshake: pixWrite is valid, pixReady is ready; a pixel transfers on a
  // rising edge where both are high, and pixWrite/pixX/pixY/pixColor hold
  // until then. Queue side: read is high in IDLE whenever the queue is not
  // empty, and the head is consumed on that same edge.

  raster_state_t              state;
  logic        [COORD_W-1:0]  cur_x;
  logic        [COORD_W-1:0]  cur_y;
  logic        [COORD_W-1:0]  end_x;
  logic        [COORD_W-1:0]  end_y;
  logic        [COLOR_W-1:0]  color;
  logic signed [DELTA_W-1:0]  dx;
  logic signed [DELTA_W-1:0]  dy;
  logic                       sx_neg;
  logic                       sy_neg;
  logic signed [ERR_W-1:0]    err;

  logic        [COORD_W-1:0]  next_x;
  logic        [COORD_W-1:0]  next_y;
  logic signed [ERR_W-1:0]    next_err;
  logic signed [DELTA_W-1:0]  head_dx;
  logic signed [DELTA_W-1:0]  head_dy;
  logic signed [ERR_W-1:0]    head_err;
  logic                       in_bounds;
  logic                       at_end;
  logic                       advance;

  line_step u_line_step (
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .next_x   (next_x),
    .next_y   (next_y),
    .next_err (next_err)
  );

  assign head_dx  = abs_delta(QStartX, QEndX);
  assign head_dy  = -abs_delta(QStartY, QEndY);
  assign head_err = {{(ERR_W-DELTA_W){head_dx[DELTA_W-1]}}, head_dx}
                  + {{(ERR_W-DELTA_W){head_dy[DELTA_W-1]}}, head_dy};

  assign in_bounds = (cur_x < SCR_W) && (cur_y < SCR_H);
  assign at_end    = (cur_x == end_x) && (cur_y == end_y);
  // Clipped points step immediately; visible points wait for the framebuffer.
  assign advance   = (state == RS_DRAW) && (!in_bounds || pixReady);

  assign read      = (state == RS_IDLE) && !empty;
  assign busy      = (state == RS_DRAW);
  assign pixWrite  = (state == RS_DRAW) && in_bounds;
  assign pixX      = cur_x;
  assign pixY      = cur_y;
  assign pixColor  = color;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= RS_IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      end_x  <= '0;
      end_y  <= '0;
      color  <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      err    <= '0;
    end else begin
      case (state)
        RS_IDLE: begin
          if (read) begin
            cur_x  <= QStartX;
            cur_y  <= QStartY;
            end_x  <= QEndX;
            end_y  <= QEndY;
            color  <= QColor;
            dx     <= head_dx;
            dy     <= head_dy;
            sx_neg <= (QEndX < QStartX);
            sy_neg <= (QEndY < QStartY);
            err    <= head_err;
            state  <= RS_DRAW;
          end
        end
        RS_DRAW: begin
          if (advance) begin
            if (at_end) begin
              state <= RS_IDLE;
            end else begin
              cur_x <= next_x;
              cur_y <= next_y;
              err   <= next_err;
            end
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avg_line_raster.sv
// Directed bench for avg_line_raster: queue model, expected-pixel scoreboard, monitor.
module tb_avg_line_raster;
  import avg_pkg::*;

  typedef struct packed {
    logic [10:0] sx;
    logic [10:0] sy;
    logic [10:0] ex;
    logic [10:0] ey;
    logic [2:0]  c;
  } line_t;

  logic          clk;
  logic          rst_b;
  logic [10:0]   q_start_x, q_start_y, q_end_x, q_end_y;
  logic [2:0]    q_color;
  logic          empty;
  logic          read;
  logic [10:0]   pix_x, pix_y;
  logic [2:0]    pix_color;
  logic          pix_write;
  logic          pix_ready;
  logic          busy;
  raster_state_t state_dbg;

  line_t         line_q[$];
  logic [24:0]   exp_q[$];
  int            acc_cyc[$];
  logic          pop_arm;
  int            n_vec, n_err, cyc, n_reads, n_busy;

  avg_line_raster #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .QStartX   (q_start_x),
    .QStartY   (q_start_y),
    .QEndX     (q_end_x),
    .QEndY     (q_end_y),
    .QColor    (q_color),
    .empty     (empty),
    .read      (read),
    .pixX      (pix_x),
    .pixY      (pix_y),
    .pixColor  (pix_color),
    .pixWrite  (pix_write),
    .pixReady  (pix_ready),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // the queue head is consumed on any edge where read was high
  always @(posedge clk) pop_arm <= read && rst_b;

  function automatic void check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // monitor / scoreboard
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_b) begin
        if (read) n_reads++;
        if (busy) n_busy++;
        check("read_in_draw", int'(read & busy), 0);
        if (pix_write && pix_ready) begin
          acc_cyc.push_back(cyc);
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_pixel: got (%0d,%0d,c%0d) expected none", pix_x, pix_y, pix_color);
          end else begin
            e = exp_q.pop_front();
            if ({pix_x, pix_y, pix_color} !== e) begin
              n_err++;
              $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                       pix_x, pix_y, pix_color, e[24:14], e[13:3], e[2:0]);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic update_head();
    empty = (line_q.size() == 0);
    if (line_q.size() != 0) begin
      q_start_x = line_q[0].sx;
      q_start_y = line_q[0].sy;
      q_end_x   = line_q[0].ex;
      q_end_y   = line_q[0].ey;
      q_color   = line_q[0].c;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_arm && line_q.size() != 0) void'(line_q.pop_front());
    update_head();
  endtask

  task automatic load_line(input int sx, input int sy, input int ex, input int ey, input int c);
    line_t l;
    l.sx = 11'(sx); l.sy = 11'(sy); l.ex = 11'(ex); l.ey = 11'(ey); l.c = 3'(c);
    line_q.push_back(l);
    update_head();
  endtask

  task automatic push_exp(input int x, input int y, input int c);
    exp_q.push_back({11'(x), 11'(y), 3'(c)});
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (line_q.size() == 0 && !busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(name, int'(done), 1);
  endtask

  initial begin
    int base, b0;
    bit reached;
    n_vec = 0; n_err = 0; cyc = 0; n_reads = 0; n_busy = 0;
    rst_b = 1'b0; pix_ready = 1'b1; empty = 1'b1;
    q_start_x = '0; q_start_y = '0; q_end_x = '0; q_end_y = '0; q_color = '0;
    tick(); tick();
    check("rst_pixwrite", int'(pix_write), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_read", int'(read), 0);
    check("rst_pixx", int'(pix_x), 0);
    check("rst_pixy", int'(pix_y), 0);
    check("rst_color", int'(pix_color), 0);
    rst_b = 1'b1;
    tick();

    // horizontal line
    base = acc_cyc.size();
    load_line(0, 0, 3, 0, 5);
    for (int i = 0; i < 4; i++) push_exp(i, 0, 5);
    wait_idle("horiz_done");
    check("horiz_reads", n_reads, 1);
    check("horiz_count", acc_cyc.size() - base, 4);
    if (acc_cyc.size() >= base + 4) check("horiz_consecutive", acc_cyc[base+3] - acc_cyc[base], 3);

    // steep line
    load_line(0, 0, 2, 5, 3);
    push_exp(0, 0, 3); push_exp(0, 1, 3); push_exp(1, 2, 3);
    push_exp(1, 3, 3); push_exp(2, 4, 3); push_exp(2, 5, 3);
    wait_idle("steep_done");

    // zero-length line
    base = acc_cyc.size();
    load_line(7, 9, 7, 9, 4);
    push_exp(7, 9, 4);
    wait_idle("zero_done");
    check("zero_count", acc_cyc.size() - base, 1);
    check("zero_state", int'(state_dbg), int'(RS_IDLE));

    // backpressure on cycles 2-4
    base = acc_cyc.size();
    load_line(0, 0, 4, 0, 2);
    for (int i = 0; i < 5; i++) push_exp(i, 0, 2);
    tick();
    tick();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_x", int'(pix_x), 1);
      check("stall_y", int'(pix_y), 0);
      check("stall_write", int'(pix_write), 1);
      check("stall_color", int'(pix_color), 2);
      tick();
    end
    check("stall_release_x", int'(pix_x), 1);
    pix_ready = 1'b1;
    wait_idle("stall_done");
    check("stall_count", acc_cyc.size() - base, 5);

    // right-edge clipping
    base = acc_cyc.size();
    b0 = n_busy;
    load_line(638, 10, 642, 10, 7);
    push_exp(638, 10, 7); push_exp(639, 10, 7);
    wait_idle("clip_done");
    check("clip_count", acc_cyc.size() - base, 2);
    check("clip_draw_cycles", n_busy - b0, 5);
    check("clip_reads", n_reads, 5);

    // back-to-back lines, then reset in the middle of the second
    base = acc_cyc.size();
    load_line(0, 0, 2, 0, 1);
    load_line(0, 5, 20, 5, 6);
    for (int i = 0; i < 3; i++) push_exp(i, 0, 1);
    for (int i = 0; i < 4; i++) push_exp(i, 5, 6);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acc_cyc.size() >= base + 7) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    check("b2b_reached", int'(reached), 1);
    rst_b = 1'b0;
    #1;
    check("async_rst_pixwrite", int'(pix_write), 0);
    check("async_rst_busy", int'(busy), 0);
    if (acc_cyc.size() >= base + 7) begin
      check("b2b_bubble", acc_cyc[base+3] - acc_cyc[base+2], 2);
      check("b2b_throughput", acc_cyc[base+1] - acc_cyc[base], 1);
    end
    check("b2b_reads", n_reads, 7);
    tick(); tick();
    rst_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_pixwrite", int'(pix_write), 0);
      check("post_rst_busy", int'(busy), 0);
    end
    check("post_rst_count", acc_cyc.size() - base, 7);
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/avg_line_raster.md
# avg_line_raster

Line rasterizer on the read side of the AVG line queue. Pops one line (start/end coordinates plus color) from the queue head, walks it with integer Bresenham stepping, and emits one pixel write per accepted cycle toward the framebuffer writer. Screen-bounds clipping and framebuffer backpressure are both handled here. Sits between `lineRegQueue` and the framebuffer port.

## Interface
- `SCREEN_W`, default 640: pixels with x ≥ SCREEN_W are clipped.
- `SCREEN_H`, default 480: pixels with y ≥ SCREEN_H are clipped.
- `clk`  in  1  single clock.
- `rst_b`  in  1  asynchronous, active-low reset.
- `QStartX`, `QStartY`, `QEndX`, `QEndY`  in  11 each  queue head coordinates, unsigned.
- `QColor`  in  3  queue head color.
- `empty`  in  1  queue has no line.
- `read`  out  1  pop strobe to queue; one-cycle pulse.
- `pixX`, `pixY`  out  11 each  current pixel coordinate.
- `pixColor`  out  3  color of the current line.
- `pixWrite`  out  1  pixel valid.
- `pixReady`  in  1  framebuffer accepts the pixel this cycle.
- `busy`  out  1  a line is latched and not yet finished.

## Operation
- FSM states: IDLE, DRAW.
- IDLE:
  - `read = ~empty`, combinational.
  - On an edge with `read=1`: latch head into curX/curY/endX/endY/color; compute dx=|endX−startX|, dy=−|endY−startY|, sx/sy = ±1, err=dx+dy; go to DRAW.
  - Head data is sampled the same cycle `read` is high.
- DRAW: the current point (curX, curY) is presented on `pixX`/`pixY`.
  - In-bounds point: `pixWrite=1`; hold until `pixReady`.
  - Out-of-bounds point (curX ≥ SCREEN_W or curY ≥ SCREEN_H): `pixWrite=0`; step without waiting.
- Step, taken on the advance edge:
  - e2 = 2·err.
  - If e2 ≥ dy: err += dy, curX += sx.
  - If e2 ≤ dx: err += dx, curY += sy.
  - Both updates use the old err and can occur in the same step.
- Termination: if the point being advanced is (endX, endY), go to IDLE instead of stepping.
- Widths:
  - dx/dy are 12-bit signed.
  - err and e2 are 14-bit signed; no overflow over the 11-bit range.
  - cur coordinates stay 11-bit unsigned and never leave the segment bounds.
- Pixel count per line = max(|Δx|, |Δy|) + 1; a zero-length line emits exactly 1 pixel.
- `pixColor` is constant for the whole line.
- `busy` = (state == DRAW).
- `read` is never asserted in DRAW.

## Timing
- Reset values: state IDLE; `read`=0 (unless `empty`=0), `pixWrite`=0, `busy`=0, `pixX`/`pixY`/`pixColor`=0; all internal registers 0.
- Latency: `read` edge → first pixel valid on the next cycle (1 cycle).
- Throughput: 1 pixel/cycle while `pixReady`=1; clipped pixels also take 1 cycle each.
- Line turnaround: after the final pixel is accepted, there is one IDLE cycle; `read` pulses there if `empty`=0. This gives 1 bubble between lines.
- `pixReady` low: `pixX`, `pixY`, `pixColor`, `pixWrite` hold stable; err and cur do not change.
- `pixReady` high while `pixWrite`=0 is ignored.
- Reset mid-line: abort immediately. The popped line is lost; no further pixels are emitted for it.
- Queue head changing during DRAW has no effect, because all line data is latched.

## Structure
- Shared `avg_pkg`: `COORD_W`=11, `COLOR_W`=3, `ERR_W`=14, state enum `raster_state_t {RS_IDLE, RS_DRAW}`.
- One sub-module, `line_step`: combinational; takes cur, err, dx, dy, sx, sy and returns next cur and next err.
- The top module holds the FSM, registers, clip compare, and handshake.

## Test plan
- Horizontal line (0,0)→(3,0), color 5, `pixReady`=1 → single `read` pulse; pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles, color 5; `busy` drops after the 4th.
- Steep line (0,0)→(2,5) → pixels (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
- Zero-length line (7,9)→(7,9) → exactly one pixel (7,9), then IDLE.
- Line (0,0)→(4,0) with `pixReady` low on cycles 2–4 → (1,0) held stable for 3 cycles; all 5 pixels delivered once each, in order.
- Line (638,10)→(642,10), SCREEN_W=640 → `pixWrite` only for x=638, 639; 5 DRAW cycles total.
- Two queued lines back to back → second `read` exactly 1 cycle after the first line's last accepted pixel. Then assert `rst_b`=0 mid-second-line → `pixWrite`, `busy` go to 0 asynchronously, and no pixels follow after release until the queue is non-empty.
